// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them to instruction memory and verifies an XOR checksum.
module imem_loader #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic                  imem_we_o,
    output logic [DEPTH_LOG2-1:0] imem_waddr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_rst_no,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [DEPTH_LOG2:0]   words_o
);

    localparam int WW = DEPTH_LOG2 + 1;
    localparam logic [16:0]   LEN_LIMIT = 17'(1) << DEPTH_LOG2;
    localparam logic [WW-1:0] WORDS_MAX = WW'(1) << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [WW-1:0]         len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [WW-1:0]         word_idx_q, word_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [DEPTH_LOG2-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WW-1:0]         words_q, words_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic [WW-1:0]         word_idx_inc;

    // rx_ready_q is a pure function of the registered state, so accepting a
    // byte never depends combinationally on rx_valid_i.
    assign accept       = rx_valid_i & rx_ready_q;
    assign len_full     = {rx_data_i, len_lo_q};
    assign word_idx_inc = word_idx_q + WW'(1);

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        words_d      = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_LEN0;
                    words_d    = '0;
                    csum_d     = '0;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    asm_d      = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    if ((len_full == 16'd0) || ({1'b0, len_full} > LEN_LIMIT)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d      = len_full[WW-1:0];
                        byte_idx_d = '0;
                        word_idx_d = '0;
                        csum_d     = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data_i;
                        2'd1: asm_d[15:8]  = rx_data_i;
                        2'd2: asm_d[23:16] = rx_data_i;
                        default: begin
                            // Top lane comes straight from the bus so the word
                            // is written the cycle after its last byte.
                            imem_we_d    = 1'b1;
                            imem_waddr_d = word_idx_q[DEPTH_LOG2-1:0];
                            imem_wdata_d = {rx_data_i, asm_q};
                            word_idx_d   = word_idx_inc;
                            words_d      = (words_q == WORDS_MAX) ? words_q : words_q + WW'(1);
                            if (word_idx_inc == len_q) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                       (state_d == S_DATA) || (state_d == S_CHK);
        busy_d       = rx_ready_d;
        done_d       = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            words_q      <= words_d;
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_waddr_o = imem_waddr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign core_rst_no  = core_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames plus hand-written corner sequences;
// expected memory writes go through a scoreboard checked by a write monitor.
module tb_imem_loader;

    localparam int DL = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          rx_valid_i;
    logic [7:0]    rx_data_i;
    logic          rx_ready_o;
    logic          imem_we_o;
    logic [DL-1:0] imem_waddr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rst_no;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [DL:0]   words_o;

    always #5 clk_i = ~clk_i;

    imem_loader #(.DEPTH_LOG2(DL)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_waddr_o (imem_waddr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_no  (core_rst_no),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .words_o      (words_o)
    );

    // Frame bytes are left-justified: byte 0 sits in frame[95:88].
    typedef struct packed {
        logic [95:0] frame;
        int          nbytes;
        int          gap_at;
        bit          start_in_gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    typedef struct packed {
        int          cyc;
        logic [DL-1:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] asm_word;
    vec_t        vecs[6];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (imem_we_o === 1'b1) begin
            $display("[TB] write addr %0d data 0x%08h at cycle %0d", imem_waddr_o, imem_wdata_o, cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         imem_waddr_o, imem_wdata_o);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(imem_waddr_o), 32'(mon_e.addr));
                check("wr_data", imem_wdata_o, mon_e.data);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic push_payload(input int p, input logic [7:0] b);
        wr_t w;
        asm_word[8*(p%4) +: 8] = b;
        if (p % 4 == 3) begin
            w.cyc  = cyc + 1;
            w.addr = DL'(p / 4);
            w.data = asm_word;
            sb.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("start_rx_ready", 32'(rx_ready_o), 1);
        check("start_core_rst", 32'(core_rst_no), 0);
        check("start_done", 32'(done_o), 0);
        check("start_error", 32'(error_o), 0);
        check("start_words", 32'(words_o), 0);
    endtask

    task automatic check_result(input bit d, input bit e, input int w);
        check("res_done", 32'(done_o), 32'(d));
        check("res_error", 32'(error_o), 32'(e));
        check("res_core_rst", 32'(core_rst_no), 32'(d));
        check("res_words", 32'(words_o), w);
        check("res_rx_ready", 32'(rx_ready_o), 0);
        check("res_busy", 32'(busy_o), 0);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_frame(input vec_t v, input int id);
        logic [7:0] b;
        do_start();
        for (int i = 0; i < v.nbytes; i++) begin
            if (i == v.gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    if (g == 1 && v.start_in_gap) start_i = 1'b1;
                    @(posedge clk_i);
                    #1;
                    start_i = 1'b0;
                end
            end
            b = v.frame[95-8*i -: 8];
            if (i >= 2 && i < v.nbytes - 1) push_payload(i - 2, b);
            send_byte(b);
        end
        check_result(v.exp_done, v.exp_err, v.exp_words);
        $display("[TB] frame %0d: done=%0b error=%0b words=%0d", id, done_o, error_o, words_o);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] cs;

        vecs[0] = '{frame: 96'h02_00_13_05_10_00_93_05_20_00_B0_00, nbytes: 11, gap_at: -1,
                    start_in_gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[1] = '{frame: 96'h02_00_13_05_10_00_93_05_20_00_B1_00, nbytes: 11, gap_at: -1,
                    start_in_gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 2};
        vecs[2] = '{frame: 96'h41_00_00_00_00_00_00_00_00_00_00_00, nbytes: 2, gap_at: -1,
                    start_in_gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[3] = '{frame: 96'h00_00_00_00_00_00_00_00_00_00_00_00, nbytes: 2, gap_at: -1,
                    start_in_gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[4] = '{frame: 96'h02_00_13_05_10_00_93_05_20_00_B0_00, nbytes: 11, gap_at: 4,
                    start_in_gap: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[5] = '{frame: 96'h01_00_EF_BE_AD_DE_22_00_00_00_00_00, nbytes: 7, gap_at: -1,
                    start_in_gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 1};

        rst_i      = 1'b1;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        asm_word   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_core_rst", 32'(core_rst_no), 0);
        check("rst_rx_ready", 32'(rx_ready_o), 0);
        check("rst_we", 32'(imem_we_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_error", 32'(error_o), 0);
        check("rst_words", 32'(words_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_waddr", 32'(imem_waddr_o), 0);
        check("rst_wdata", imem_wdata_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

        // Bytes offered while DONE must not be consumed or change anything.
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h5A;
        repeat (3) @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        check_result(1'b1, 1'b0, 1);

        // Largest legal frame: 64 words, exercises the top address and words_o limit.
        do_start();
        send_byte(8'h40);
        send_byte(8'h00);
        cs = 8'h00;
        for (int p = 0; p < 256; p++) begin
            b  = 8'($urandom);
            cs = cs ^ b;
            push_payload(p, b);
            send_byte(b);
        end
        check("max_rx_ready_chk", 32'(rx_ready_o), 1);
        send_byte(cs);
        check_result(1'b1, 1'b0, 64);
        $display("[TB] frame max: done=%0b error=%0b words=%0d", done_o, error_o, words_o);
        drain();

        // Reset after 5 payload bytes: only word 0 is written, partial word dropped.
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        push_payload(0, 8'h13); send_byte(8'h13);
        push_payload(1, 8'h05); send_byte(8'h05);
        push_payload(2, 8'h10); send_byte(8'h10);
        push_payload(3, 8'h00); send_byte(8'h00);
        push_payload(4, 8'h93); send_byte(8'h93);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midrst_rx_ready", 32'(rx_ready_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_words", 32'(words_o), 0);
        check("midrst_core_rst", 32'(core_rst_no), 0);
        check("midrst_we", 32'(imem_we_o), 0);
        $display("[TB] reset mid-load: busy=%0b words=%0d", busy_o, words_o);
        drain();
        run_frame(vecs[0], 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
